// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO for any depth, including depths that are not a power of two.
// Provides occupancy, threshold flags, sticky error flags, flush, and full-state pass-through.
module sync_fifo_flagged #(
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  input  logic              flush_i,
  input  logic              err_clr_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [CW-1:0]     count_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     w_ptr;
  logic [PW-1:0]     r_ptr;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              push_acc;
  logic              pop_acc;
  logic              ov_set;
  logic              un_set;
  logic              overflow;
  logic              underflow;

  // Explicit wrap so that depths that are not a power of two do not rely on pointer overflow.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    pop_acc  = pop_i && !empty && !flush_i;
    push_acc = push_i && (!full || pop_i) && !flush_i;
    ov_set   = push_i && full && !pop_i && !flush_i;
    un_set   = pop_i && empty && !flush_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else if (flush_i) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else begin
      if (push_acc) w_ptr <= bump(w_ptr);
      if (pop_acc)  r_ptr <= bump(r_ptr);
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The storage has no reset. Its contents cannot be observed while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_acc) mem[w_ptr] <= push_data_i;
  end

  // When a set and a clear arrive in the same cycle, the set takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ov_set | (overflow & ~err_clr_i);
      underflow <= un_set | (underflow & ~err_clr_i);
    end
  end

  assign pop_data_o     = empty ? '0 : mem[r_ptr];
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count >= AF_CNT);
  assign almost_empty_o = (count <= AE_CNT);
  assign count_o        = count;
  assign overflow_o     = overflow;
  assign underflow_o    = underflow;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Scoreboard bench for sync_fifo_flagged: a queue-based reference model feeds expected-status and expected-data queues.
// A separate monitor process drains those queues and compares them against the DUT.
module tb_sync_fifo_flagged;

  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;

  typedef struct {
    int unsigned count;
    logic        full, empty, af, ae, ov, un;
    logic [7:0]  head;
  } st_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       push_i = 1'b0;
  logic [7:0] push_data_i = '0;
  logic       pop_i = 1'b0;
  logic [7:0] pop_data_o;
  logic       flush_i = 1'b0;
  logic       err_clr_i = 1'b0;
  logic       full_o, empty_o, almost_full_o, almost_empty_o;
  logic [2:0] count_o;
  logic       overflow_o, underflow_o;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [7:0] model_q[$];
  logic       m_ov = 1'b0;
  logic       m_un = 1'b0;
  st_t        exp_st_q[$];
  logic [7:0] exp_data_q[$];

  sync_fifo_flagged #(.DEPTH(DEPTH), .DATA_W(8), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset_n(reset_n), .push_i(push_i), .push_data_i(push_data_i),
    .pop_i(pop_i), .pop_data_o(pop_data_o), .flush_i(flush_i), .err_clr_i(err_clr_i),
    .full_o(full_o), .empty_o(empty_o), .almost_full_o(almost_full_o),
    .almost_empty_o(almost_empty_o), .count_o(count_o), .overflow_o(overflow_o),
    .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic st_t model_status();
    st_t s;
    s.count = model_q.size();
    s.full  = (s.count == DEPTH);
    s.empty = (s.count == 0);
    s.af    = (s.count >= AF);
    s.ae    = (s.count <= AE);
    s.ov    = m_ov;
    s.un    = m_un;
    s.head  = s.empty ? 8'h00 : model_q[0];
    return s;
  endfunction

  // Publish the expected pre-edge status, drive one cycle of stimulus, then advance the model.
  task automatic step(input logic psh, input logic [7:0] d, input logic pp,
                      input logic fl, input logic clr);
    bit was_empty, was_full, pa, wa;
    @(negedge clk);
    exp_st_q.push_back(model_status());
    push_i = psh; push_data_i = d; pop_i = pp; flush_i = fl; err_clr_i = clr;
    was_empty = (model_q.size() == 0);
    was_full  = (model_q.size() == DEPTH);
    pa = pp && !was_empty && !fl;
    wa = psh && (!was_full || pp) && !fl;
    if (pa) exp_data_q.push_back(model_q[0]);
    m_ov = (psh && was_full && !pp && !fl) || (m_ov && !clr);
    m_un = (pp && was_empty && !fl) || (m_un && !clr);
    if (fl) model_q.delete();
    else begin
      if (pa) void'(model_q.pop_front());
      if (wa) model_q.push_back(d);
    end
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"}, 32'(count_o), 0);
    chk({tag, "_empty"}, 32'(empty_o), 1);
    chk({tag, "_full"},  32'(full_o), 0);
    chk({tag, "_ae"},    32'(almost_empty_o), 1);
    chk({tag, "_af"},    32'(almost_full_o), 0);
    chk({tag, "_data"},  32'(pop_data_o), 0);
    chk({tag, "_ov"},    32'(overflow_o), 0);
    chk({tag, "_un"},    32'(underflow_o), 0);
  endtask

  // Monitor: samples away from the edge, once the driver's inputs for the cycle have settled.
  initial begin
    st_t  s;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_st_q.size() > 0) begin
        s = exp_st_q.pop_front();
        chk("count",    32'(count_o), s.count);
        chk("full",     32'(full_o), 32'(s.full));
        chk("empty",    32'(empty_o), 32'(s.empty));
        chk("almost_f", 32'(almost_full_o), 32'(s.af));
        chk("almost_e", 32'(almost_empty_o), 32'(s.ae));
        chk("overflow", 32'(overflow_o), 32'(s.ov));
        chk("underflw", 32'(underflow_o), 32'(s.un));
        chk("head",     32'(pop_data_o), 32'(s.head));
      end
      if (reset_n && pop_i && !flush_i && !empty_o) begin
        if (exp_data_q.size() == 0) chk("unexpected_pop", 32'(pop_data_o), 32'hFFFF_FFFF);
        else begin
          e = exp_data_q.pop_front();
          chk("pop_data", 32'(pop_data_o), 32'(e));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk_reset_outputs("por");
    @(negedge clk);
    reset_n = 1'b1;

    // Fill with 0x11..0x55, then push once more while full to trigger an overflow.
    for (int unsigned i = 1; i <= 5; i++) step(1'b1, 8'(i * 8'h11), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // While full, push and pop in the same cycle, then drain.
    for (int unsigned i = 1; i <= 5; i++) step(1'b1, 8'(i * 8'h11), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();

    // Alternate push and pop of 0x01..0x0C so both pointers wrap.
    for (int unsigned i = 1; i <= 12; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    idle();

    // Push and pop together while empty, then clear the error, then clear and underflow in the same cycle.
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Flush with 3 entries held, then apply an asynchronous reset mid-stream.
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    idle();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; err_clr_i = 1'b0;
    model_q.delete(); m_ov = 1'b0; m_un = 1'b0;
    exp_data_q.delete();
    @(negedge clk);
    reset_n = 1'b1;

    // Randomised traffic.
    for (int unsigned i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10);
    end
    idle();
    @(negedge clk);
    #3;
    chk("leftover_status", exp_st_q.size(), 0);
    chk("leftover_data", exp_data_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
